// File: rtl/regfile_write_port_pkg.sv
// Shared types and constants for the register-bank write side.
// Select codes count down from reg_a (3'b111) to reg_h (3'b000).
package regfile_write_port_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;

  localparam logic [2:0] SEL_A = 3'b111;
  localparam logic [2:0] SEL_B = 3'b110;
  localparam logic [2:0] SEL_C = 3'b101;
  localparam logic [2:0] SEL_D = 3'b100;
  localparam logic [2:0] SEL_E = 3'b011;
  localparam logic [2:0] SEL_F = 3'b010;
  localparam logic [2:0] SEL_G = 3'b001;
  localparam logic [2:0] SEL_H = 3'b000;

  typedef struct packed {
    logic [2:0]       sel;
    logic [WIDTH-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/regfile_write_port_write_queue.sv
// Two-entry in-order write queue; an entry pushed on edge N is poppable from edge N+1.
// Pushes are ignored when full and pops when empty, so the caller may gate loosely.
module write_queue
  import regfile_write_port_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  wq_entry_t       push_entry_i,
  input  logic            pop_i,
  output logic [1:0]      count_o,
  output wq_entry_t       head_o,
  output logic [1:0]      slot_vld_o,
  output logic [1:0][2:0] slot_sel_o
);

  wq_entry_t  slot_q [2];
  logic       head_q, head_d;
  logic [1:0] count_q, count_d;
  logic       tail;
  logic       push_ok, pop_ok;

  assign push_ok = push_i && (count_q != 2'd2);
  assign pop_ok  = pop_i && (count_q != 2'd0);

  // Empty queue writes the head slot; one entry means the tail is the other slot.
  assign tail = head_q ^ (count_q == 2'd1);

  always_comb begin
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    head_d  = pop_ok ? ~head_q : head_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      for (int i = 0; i < 2; i++) slot_q[i] <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      if (push_ok) slot_q[tail] <= push_entry_i;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      slot_vld_o[i] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'(i)));
      slot_sel_o[i] = slot_q[i].sel;
    end
  end

  assign count_o = count_q;
  assign head_o  = slot_q[head_q];

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 8 x WIDTH register bank: queued writes commit one per cycle on commit_en.
// Accept-to-commit is 2 edges minimum; wr_ready drops only while two writes are queued.
module regfile_write_port
  import regfile_write_port_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit_en,
  input  logic [2:0]       rd_sel0,
  input  logic [2:0]       rd_sel1,
  output logic             hazard0,
  output logic             hazard1,
  output logic [1:0]       pending,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] reg_c,
  output logic [WIDTH-1:0] reg_d,
  output logic [WIDTH-1:0] reg_e,
  output logic [WIDTH-1:0] reg_f,
  output logic [WIDTH-1:0] reg_g,
  output logic [WIDTH-1:0] reg_h
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] we;
  logic             push, commit;
  wq_entry_t        push_entry, head;
  logic [1:0]       slot_vld;
  logic [1:0][2:0]  slot_sel;

  assign wr_ready   = (pending != 2'd2);
  assign push       = wr_valid && wr_ready;
  assign commit     = commit_en && (pending != 2'd0);
  assign push_entry = '{sel: wr_sel, data: wr_data};

  write_queue u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (commit),
    .count_o      (pending),
    .head_o       (head),
    .slot_vld_o   (slot_vld),
    .slot_sel_o   (slot_sel)
  );

  assign we = commit ? (NREGS'(1) << head.sel) : '0;

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = we[i] ? head.data : regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Hazards look only at queued entries, never at this cycle's wr_* request.
  always_comb begin
    hazard0 = 1'b0;
    hazard1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      hazard0 = hazard0 | (slot_vld[i] && (slot_sel[i] == rd_sel0));
      hazard1 = hazard1 | (slot_vld[i] && (slot_sel[i] == rd_sel1));
    end
  end

  assign reg_a = regs_q[SEL_A];
  assign reg_b = regs_q[SEL_B];
  assign reg_c = regs_q[SEL_C];
  assign reg_d = regs_q[SEL_D];
  assign reg_e = regs_q[SEL_E];
  assign reg_f = regs_q[SEL_F];
  assign reg_g = regs_q[SEL_G];
  assign reg_h = regs_q[SEL_H];

endmodule
